ntt_layer_sequencer: RTL and testbench

- Upstream issue controller for the radix-2 NTT butterfly unit. Per start, it walks the full 7-layer Kyber forward NTT over the 256-coefficient Z-register bank, covering len = 128 down to 2.
- Each cycle it emits one butterfly command: left index, right index and twiddle.
- It inserts drain gaps between layers so each layer reads only committed results, and counts butterfly completions to signal done.

---
 rtl/ntt_pkg.sv | 38 +++
 rtl/ntt_layer_sequencer_if.sv | 26 ++
 rtl/ntt_twiddle_rom.sv | 33 +++
 rtl/ntt_layer_sequencer.sv | 154 +++++++++++++++
 tb/tb_ntt_layer_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, types and index arithmetic for the NTT
// issue logic. Imported by the layer sequencer and by the twiddle ROM.
//   bf_cmd(layer, c) : left/right coefficient indices and twiddle ROM
//                      address for issue counter c of a forward layer.
package ntt_pkg;

   localparam int MOD_Q        = 3329;
   localparam int N_COEFF      = 256;
   localparam int N_LAYERS     = 7;
   localparam int N_BFLY_TOTAL = 896;

   typedef logic [15:0] coeff_t;
   typedef logic [7:0]  idx_t;

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FLUSH, DONE} seq_state_e;

   typedef struct packed {
      idx_t       left;
      idx_t       right;
      logic [6:0] k;
   } bf_cmd_t;

   // Layer L has len = 128 >> L; group g = c >> (7-L) starts at g*2*len.
   // Twiddle index k = 2^L + g walks the zeta table in bit-reversed order.
   function automatic bf_cmd_t bf_cmd(input logic [2:0] layer, input logic [6:0] c);
      bf_cmd_t    cmd;
      idx_t       len;
      logic [6:0] g;
      len       = 8'd128 >> layer;
      g         = c >> (3'd7 - layer);
      cmd.left  = idx_t'({1'b0, g} << (4'd8 - {1'b0, layer}))
                | idx_t'(c & 7'(len - 8'd1));
      cmd.right = cmd.left + len;
      cmd.k     = 7'(8'd1 << layer) + g;
      return cmd;
   endfunction

endpackage

// File: rtl/ntt_layer_sequencer_if.sv
// ntt_layer_sequencer_if: command/completion link between the layer
// sequencer (master) and the radix-2 butterfly unit (slave).
//   bf_ready_i     : butterfly accepts a command this cycle
//   bf_valid_o     : command valid
//   left_idx_o     : left coefficient index
//   right_idx_o    : right coefficient index
//   twiddle_o      : zeta for the current group
//   bf_out_valid_i : butterfly completion strobe
// Handshake: a command transfers in every cycle where bf_valid_o and
// bf_ready_i are both high. The master only raises bf_valid_o in cycles
// where bf_ready_i is already high, so bf_valid_o depends combinationally
// on bf_ready_i; index and twiddle fields are registered and stay stable
// while bf_ready_i is low. bf_out_valid_i has no back-pressure.
interface ntt_layer_sequencer_if #(parameter int W = 16);
   logic         bf_ready_i;
   logic         bf_valid_o;
   logic [7:0]   left_idx_o;
   logic [7:0]   right_idx_o;
   logic [W-1:0] twiddle_o;
   logic         bf_out_valid_i;

   modport master (input bf_ready_i, bf_out_valid_i,
                   output bf_valid_o, left_idx_o, right_idx_o, twiddle_o);
   modport slave  (output bf_ready_i, bf_out_valid_i,
                   input bf_valid_o, left_idx_o, right_idx_o, twiddle_o);
endinterface

// File: rtl/ntt_twiddle_rom.sv
// ntt_twiddle_rom: combinational 128 x 16 Kyber zeta table, reference
// values mapped into [0, 3329). Entry 0 is unused by the forward NTT.
//   addr : table index 0..127
//   data : zeta value
module ntt_twiddle_rom
   import ntt_pkg::*;
(
   input  logic [6:0] addr,
   output coeff_t     data
);

   localparam coeff_t ZETAS [128] = '{
      16'd2285, 16'd2571, 16'd2970, 16'd1812, 16'd1493, 16'd1422, 16'd287,  16'd202,
      16'd3158, 16'd622,  16'd1577, 16'd182,  16'd962,  16'd2127, 16'd1855, 16'd1468,
      16'd573,  16'd2004, 16'd264,  16'd383,  16'd2500, 16'd1458, 16'd1727, 16'd3199,
      16'd2648, 16'd1017, 16'd732,  16'd608,  16'd1787, 16'd411,  16'd3124, 16'd1758,
      16'd1223, 16'd652,  16'd2777, 16'd1015, 16'd2036, 16'd1491, 16'd3047, 16'd1785,
      16'd516,  16'd3321, 16'd3009, 16'd2663, 16'd1711, 16'd2167, 16'd126,  16'd1469,
      16'd2476, 16'd3239, 16'd3058, 16'd830,  16'd107,  16'd1908, 16'd3082, 16'd2378,
      16'd2931, 16'd961,  16'd1821, 16'd2604, 16'd448,  16'd2264, 16'd677,  16'd2054,
      16'd2226, 16'd430,  16'd555,  16'd843,  16'd2078, 16'd871,  16'd1550, 16'd105,
      16'd422,  16'd587,  16'd177,  16'd3094, 16'd3038, 16'd2869, 16'd1574, 16'd1653,
      16'd3083, 16'd778,  16'd1159, 16'd3182, 16'd2552, 16'd1483, 16'd2727, 16'd1119,
      16'd1739, 16'd644,  16'd2457, 16'd349,  16'd418,  16'd329,  16'd3173, 16'd3254,
      16'd817,  16'd1097, 16'd603,  16'd610,  16'd1322, 16'd2044, 16'd1864, 16'd384,
      16'd2114, 16'd3193, 16'd1218, 16'd1994, 16'd2455, 16'd220,  16'd2142, 16'd1670,
      16'd2144, 16'd1799, 16'd2051, 16'd794,  16'd1819, 16'd2475, 16'd2459, 16'd478,
      16'd3221, 16'd3021, 16'd996,  16'd991,  16'd958,  16'd1869, 16'd1522, 16'd1628
   };

   assign data = ZETAS[addr];

endmodule

// File: rtl/ntt_layer_sequencer.sv
// ntt_layer_sequencer: issues the 896 butterflies of the 7-layer Kyber
// forward NTT (len 128 down to 2), one per cycle while the butterfly is
// ready, with a drain gap between layers, then waits for all completions.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : begin a transform (sampled only in IDLE)
//   busy_o     : high in every state except IDLE
//   done_o     : one-cycle pulse after the last completion
//   err_o      : sticky unexpected-completion flag, cleared on start
//   layer_o    : current layer 0..6
//   state_o    : FSM state (debug)
//   bf         : butterfly command/completion link (master side)
module ntt_layer_sequencer
   import ntt_pkg::*;
#(
   parameter int W          = 16,
   parameter int BF_LATENCY = 4,
   parameter int DRAIN_GAP  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic [2:0] layer_o,
   output seq_state_e state_o,
   ntt_layer_sequencer_if.master bf
);

   // Never drain for less than the butterfly needs to commit its writes.
   localparam int         GAP      = (DRAIN_GAP < BF_LATENCY - 1) ? BF_LATENCY - 1 : DRAIN_GAP;
   localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
   localparam logic [9:0] TOTAL    = 10'(N_BFLY_TOTAL);

   seq_state_e   state, state_nxt;
   logic [6:0]   c;
   logic [2:0]   layer;
   logic [3:0]   dcnt;
   logic [9:0]   outcnt;
   logic         err;
   idx_t         left_q, right_q;
   logic [W-1:0] tw_q;

   logic         issue, last_c, drain_end, start_ok, err_hit, cnt_en, flush_end, load_cmd;
   logic [2:0]   cmd_layer;
   logic [6:0]   cmd_c;
   bf_cmd_t      cmd;
   coeff_t       rom_data;

   assign issue     = (state == ISSUE) && bf.bf_ready_i;
   assign last_c    = (c == 7'd127);
   assign drain_end = (state == DRAIN) && (dcnt == GAP_LAST);
   assign start_ok  = (state == IDLE) && start_i;
   assign err_hit   = bf.bf_out_valid_i && ((state == IDLE) || (outcnt == TOTAL));
   assign cnt_en    = bf.bf_out_valid_i && !err_hit;
   // Look at the count after this cycle's completion so DONE follows the
   // last completion directly.
   assign flush_end = (outcnt == TOTAL) || (cnt_en && (outcnt == TOTAL - 10'd1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = ISSUE;
         ISSUE:   if (issue && last_c) state_nxt = (layer == 3'd6) ? FLUSH : DRAIN;
         DRAIN:   if (dcnt == GAP_LAST) state_nxt = ISSUE;
         FLUSH:   if (flush_end) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy_o        = (state != IDLE);
      done_o        = (state == DONE);
      bf.bf_valid_o = issue;
   end

   // The command registers always hold the command about to be issued, so
   // they are loaded with the next (layer, c) whenever ISSUE is entered or
   // an issue inside a layer is accepted.
   always_comb begin
      cmd_layer = layer;
      cmd_c     = c + 7'd1;
      load_cmd  = 1'b0;
      case (state)
         IDLE: begin
            cmd_layer = 3'd0;
            cmd_c     = 7'd0;
            load_cmd  = start_i;
         end
         ISSUE: load_cmd = issue && !last_c;
         DRAIN: begin
            cmd_layer = layer + 3'd1;
            cmd_c     = 7'd0;
            load_cmd  = drain_end;
         end
         default: ;
      endcase
   end

   assign cmd = bf_cmd(cmd_layer, cmd_c);

   ntt_twiddle_rom u_rom (
      .addr (cmd.k),
      .data (rom_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c       <= '0;
         layer   <= '0;
         dcnt    <= '0;
         outcnt  <= '0;
         err     <= 1'b0;
         left_q  <= '0;
         right_q <= '0;
         tw_q    <= '0;
      end else begin
         if (start_ok) begin
            c      <= '0;
            layer  <= '0;
            outcnt <= '0;
         end else begin
            if (issue)     c      <= c + 7'd1;   // 127 wraps to 0 for the next layer
            if (drain_end) layer  <= layer + 3'd1;
            if (cnt_en)    outcnt <= outcnt + 10'd1;
         end
         dcnt <= (state == DRAIN) ? dcnt + 4'd1 : 4'd0;
         if (err_hit)       err <= 1'b1;
         else if (start_ok) err <= 1'b0;
         if (load_cmd) begin
            left_q  <= cmd.left;
            right_q <= cmd.right;
            tw_q    <= W'(rom_data);
         end
      end
   end

   assign err_o          = err;
   assign layer_o        = layer;
   assign state_o        = state;
   assign bf.left_idx_o  = left_q;
   assign bf.right_idx_o = right_q;
   assign bf.twiddle_o   = tw_q;

endmodule

// File: tb/tb_ntt_layer_sequencer.sv
// tb_ntt_layer_sequencer: directed bench for the NTT layer sequencer with a
// latency-4 butterfly model, a z-register write hazard scoreboard and a
// table of hand-computed command vectors checked per run.
module tb_ntt_layer_sequencer;
   import ntt_pkg::*;

   localparam int W          = 16;
   localparam int BF_LATENCY = 4;
   localparam int LOG_N      = 1024;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_i = 1'b0;
   logic busy_o, done_o, err_o;
   logic [2:0] layer_o;
   seq_state_e state_o;
   logic [3:0] pipe;
   logic stray = 1'b0;

   always #5 clk = ~clk;

   ntt_layer_sequencer_if #(.W(W)) bf ();

   ntt_layer_sequencer #(.W(W), .BF_LATENCY(BF_LATENCY), .DRAIN_GAP(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .err_o   (err_o),
      .layer_o (layer_o),
      .state_o (state_o),
      .bf      (bf)
   );

   // Butterfly model: completion strobe BF_LATENCY cycles after acceptance.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe <= '0;
      else        pipe <= {pipe[2:0], bf.bf_valid_o & bf.bf_ready_i};
   end
   assign bf.bf_out_valid_i = pipe[3] | stray;

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;

   logic         log_v [LOG_N];
   idx_t         log_l [LOG_N];
   idx_t         log_r [LOG_N];
   logic [15:0]  log_t [LOG_N];
   int           pend_until [256];
   int           issues, dones, done_cyc, hazards, stall_valid;
   logic         err_c1, busy_end, err_end;

   typedef struct {
      int          run_id;
      int          cyc;
      logic        v;
      idx_t        l;
      idx_t        r;
      logic [15:0] tw;
      string       name;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Pulses start_i into edge 0, then runs cycles 1..max_cyc, logging the
   // command bus and checking hazards. Cycle n is the one sampled at edge n.
   task automatic run(input int stall_at, input int stall_len, input int restart_at,
                      input int reset_at, input int max_cyc);
      issues = 0; dones = 0; done_cyc = -1; hazards = 0; stall_valid = 0;
      for (int i = 0; i < 256; i++) pend_until[i] = -100;
      for (int i = 0; i < LOG_N; i++) log_v[i] = 1'b0;
      @(negedge clk);
      start_i = 1'b1;
      bf.bf_ready_i = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         @(negedge clk);
         start_i = (cyc == restart_at);
         bf.bf_ready_i = !(cyc >= stall_at && cyc < stall_at + stall_len);
         if (cyc == reset_at) rst_n = 1'b0;
         if (cyc == reset_at + 1) rst_n = 1'b1;
         #1;
         if (cyc < LOG_N) begin
            log_v[cyc] = bf.bf_valid_o;
            log_l[cyc] = bf.left_idx_o;
            log_r[cyc] = bf.right_idx_o;
            log_t[cyc] = bf.twiddle_o;
         end
         if (cyc == 1) err_c1 = err_o;
         if (bf.bf_valid_o) begin
            issues++;
            if (pend_until[bf.left_idx_o] >= cyc || pend_until[bf.right_idx_o] >= cyc) hazards++;
            pend_until[bf.left_idx_o]  = cyc + BF_LATENCY - 1;
            pend_until[bf.right_idx_o] = cyc + BF_LATENCY - 1;
            if (cyc >= stall_at && cyc < stall_at + stall_len) stall_valid++;
         end
         if (done_o) begin
            dones++;
            done_cyc = cyc;
         end
         if (cyc == reset_at) begin
            check("rst_mid_busy",  32'(busy_o), 0);
            check("rst_mid_done",  32'(done_o), 0);
            check("rst_mid_err",   32'(err_o), 0);
            check("rst_mid_layer", 32'(layer_o), 0);
            check("rst_mid_valid", 32'(bf.bf_valid_o), 0);
            check("rst_mid_left",  32'(bf.left_idx_o), 0);
            check("rst_mid_right", 32'(bf.right_idx_o), 0);
            check("rst_mid_tw",    32'(bf.twiddle_o), 0);
         end
      end
      busy_end = busy_o;
      err_end  = err_o;
      start_i  = 1'b0;
      rst_n    = 1'b1;
   endtask

   task automatic apply_vecs(input int run_id);
      foreach (vecs[i]) begin
         if (vecs[i].run_id == run_id) begin
            check({vecs[i].name, "_valid"}, 32'(log_v[vecs[i].cyc]), 32'(vecs[i].v));
            check({vecs[i].name, "_left"},  32'(log_l[vecs[i].cyc]), 32'(vecs[i].l));
            check({vecs[i].name, "_right"}, 32'(log_r[vecs[i].cyc]), 32'(vecs[i].r));
            check({vecs[i].name, "_tw"},    32'(log_t[vecs[i].cyc]), 32'(vecs[i].tw));
         end
      end
   endtask

   // ---------------- test ----------------
   initial begin
      bf.bf_ready_i = 1'b1;

      // run 0: nominal transform
      vecs.push_back('{0, 1,   1'b1, 8'd0,   8'd128, 16'd2571, "l0_first"});
      vecs.push_back('{0, 128, 1'b1, 8'd127, 8'd255, 16'd2571, "l0_last"});
      vecs.push_back('{0, 129, 1'b0, 8'd127, 8'd255, 16'd2571, "l0_drain"});
      vecs.push_back('{0, 132, 1'b1, 8'd0,   8'd64,  16'd2970, "l1_first"});
      vecs.push_back('{0, 196, 1'b1, 8'd128, 8'd192, 16'd1812, "l1_grp1"});
      vecs.push_back('{0, 787, 1'b1, 8'd0,   8'd2,   16'd2226, "l6_c0"});
      vecs.push_back('{0, 788, 1'b1, 8'd1,   8'd3,   16'd2226, "l6_c1"});
      vecs.push_back('{0, 789, 1'b1, 8'd4,   8'd6,   16'd430,  "l6_c2"});
      vecs.push_back('{0, 790, 1'b1, 8'd5,   8'd7,   16'd430,  "l6_c3"});
      vecs.push_back('{0, 914, 1'b1, 8'd253, 8'd255, 16'd1628, "l6_last"});
      vecs.push_back('{0, 915, 1'b0, 8'd253, 8'd255, 16'd1628, "flush"});
      // run 1: stall of 5 at layer 2, c=40
      vecs.push_back('{1, 302, 1'b1, 8'd71,  8'd103, 16'd1422, "st_c39"});
      vecs.push_back('{1, 303, 1'b0, 8'd72,  8'd104, 16'd1422, "st_hold0"});
      vecs.push_back('{1, 307, 1'b0, 8'd72,  8'd104, 16'd1422, "st_hold4"});
      vecs.push_back('{1, 308, 1'b1, 8'd72,  8'd104, 16'd1422, "st_c40"});
      vecs.push_back('{1, 309, 1'b1, 8'd73,  8'd105, 16'd1422, "st_c41"});

      repeat (3) @(negedge clk);
      #1;
      check("rst_busy",  32'(busy_o), 0);
      check("rst_done",  32'(done_o), 0);
      check("rst_err",   32'(err_o), 0);
      check("rst_layer", 32'(layer_o), 0);
      check("rst_valid", 32'(bf.bf_valid_o), 0);
      check("rst_left",  32'(bf.left_idx_o), 0);
      check("rst_right", 32'(bf.right_idx_o), 0);
      check("rst_tw",    32'(bf.twiddle_o), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Stray completion while IDLE raises err_o.
      @(negedge clk);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      #1;
      check("stray_err", 32'(err_o), 1);

      // Nominal transform; the start clears the stray error.
      run(-1, 0, -1, -1, 940);
      check("nom_err_cleared", 32'(err_c1), 0);
      check("nom_done_cyc",    32'(done_cyc), 919);
      check("nom_done_count",  32'(dones), 1);
      check("nom_issues",      32'(issues), 896);
      check("nom_hazards",     32'(hazards), 0);
      check("nom_busy_end",    32'(busy_end), 0);
      check("nom_err_end",     32'(err_end), 0);
      apply_vecs(0);

      // Stall at layer 2 c=40 plus an ignored start while busy.
      repeat (4) @(negedge clk);
      run(303, 5, 300, -1, 940);
      check("stall_done_cyc",   32'(done_cyc), 924);
      check("stall_done_count", 32'(dones), 1);
      check("stall_issues",     32'(issues), 896);
      check("stall_hazards",    32'(hazards), 0);
      check("stall_valid",      32'(stall_valid), 0);
      check("stall_err_end",    32'(err_end), 0);
      apply_vecs(1);

      // Reset in the middle of layer 3 abandons the transform.
      repeat (4) @(negedge clk);
      run(-1, 0, -1, 500, 700);
      check("rst_run_issues",   32'(issues), 490);
      check("rst_run_no_done",  32'(dones), 0);
      check("rst_run_busy_end", 32'(busy_end), 0);
      check("rst_run_err_end",  32'(err_end), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
